nios_base_cpu_oci_trace_drain: RTL and testbench

Parametrised trace capture and drain block for the Nios OCI debug path. Each cycle it accepts a packed compressed-trace word (`dct_buffer`) holding up to `LANES` lanes, with the valid-lane count in `dct_count`. It queues the word in a `DEPTH`-entry FIFO and serialises the valid lanes one per cycle over a valid/ready port. End-of-test signals drive a run → drain → done sequence, so a bench or host logger sees every captured lane before the test closes.

---
 rtl/nios_base_cpu_oci_trace_drain.sv | 180 ++++++++++++++++++
 tb/tb_nios_base_cpu_oci_trace_drain.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_base_cpu_oci_trace_drain.sv
// nios_base_cpu_oci_trace_drain
// Captures packed compressed-trace words into a DEPTH-entry FIFO and
// serialises their valid lanes one per cycle over a valid/ready port.
// End-of-test inputs drive a RUN -> DRAIN -> DONE sequence.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   dct_buffer/count/valid trace word in (lane 0 = LSBs), valid-lane count, qualifier
//   test_ending           stop capture and drain the FIFO
//   test_has_ended        abort: flush the FIFO and go to DONE
//   lane_data/valid/last  serialised lane out (combinational from FIFO head)
//   lane_ready            consumer accepts the current lane
//   overflow              sticky, a word was dropped on a full FIFO
//   dropped_count         saturating count of dropped words
//   drained               state is DONE
//   trace_checksum        running XOR of handed-off lanes
//
// Optional feature: define NIOS_OCI_TRACE_CHECKSUM_EN to build the checksum
// register; otherwise trace_checksum is tied to zero.
module nios_base_cpu_oci_trace_drain #(
  parameter int unsigned LANE_W  = 10,
  parameter int unsigned LANES   = 3,
  parameter int unsigned COUNT_W = 4,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [LANES*LANE_W-1:0] dct_buffer,
  input  logic [COUNT_W-1:0]      dct_count,
  input  logic                    dct_valid,
  input  logic                    test_ending,
  input  logic                    test_has_ended,
  output logic [LANE_W-1:0]       lane_data,
  output logic                    lane_valid,
  input  logic                    lane_ready,
  output logic                    lane_last,
  output logic                    overflow,
  output logic [15:0]             dropped_count,
  output logic                    drained,
  output logic [LANE_W-1:0]       trace_checksum
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned CW     = $clog2(LANES + 1);
  localparam int unsigned WORD_W = LANES * LANE_W;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_q, drop_d;

  logic [WORD_W-1:0] data_mem [DEPTH];
  logic [CW-1:0]     cnt_mem  [DEPTH];

  logic [CW-1:0]     eff_cnt;
  logic              empty, full;
  logic [WORD_W-1:0] head_word;
  logic [CW-1:0]     head_cnt;
  logic [LANE_W-1:0] lane_sel;
  logic              capture_ok, push, drop, handoff, pop;

  // Effective lane count: dct_count clamped to LANES
  always_comb begin
    if (32'(dct_count) > LANES) eff_cnt = CW'(LANES);
    else                        eff_cnt = CW'(dct_count);
  end

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign head_word = data_mem[rd_q[AW-1:0]];
  assign head_cnt  = cnt_mem[rd_q[AW-1:0]];

  // Lane mux from the head entry
  always_comb begin
    lane_sel = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (idx_q == CW'(l)) lane_sel = head_word[l*LANE_W +: LANE_W];
    end
  end

  assign lane_valid = !empty && (state_q != ST_DONE);
  assign lane_data  = lane_valid ? lane_sel : '0;
  assign lane_last  = lane_valid && (idx_q == (head_cnt - CW'(1)));
  assign handoff    = lane_valid && lane_ready;
  assign pop        = handoff && lane_last;

  // Capture only in RUN (includes the RUN->DRAIN cycle); full is judged
  // before any pop this cycle, so there is no pop bypass.
  assign capture_ok = dct_valid && (eff_cnt != '0) && (state_q == ST_RUN);
  assign push       = capture_ok && !full;
  assign drop       = capture_ok && full;

  // Next state, pointers, lane index and drop statistics
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);

    if (handoff) begin
      if (lane_last) idx_d = '0;
      else           idx_d = idx_q + CW'(1);
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    unique case (state_q)
      ST_RUN:   if (test_ending) state_d = ST_DRAIN;
      ST_DRAIN: if (empty)       state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase

    // Abort wins over everything and discards queued words
    if (test_has_ended) begin
      state_d = ST_DONE;
      wr_d    = '0;
      rd_d    = '0;
      idx_d   = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      wr_q       <= '0;
      rd_q       <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO storage; contents are only observed through the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_q[AW-1:0]] <= dct_buffer;
      cnt_mem[wr_q[AW-1:0]]  <= eff_cnt;
    end
  end

  assign overflow      = overflow_q;
  assign dropped_count = drop_q;
  assign drained       = (state_q == ST_DONE);

`ifdef NIOS_OCI_TRACE_CHECKSUM_EN
  logic [LANE_W-1:0] cks_q;

  // Running XOR of every handed-off lane
  always_ff @(posedge clk) begin
    if (!reset_n)     cks_q <= '0;
    else if (handoff) cks_q <= cks_q ^ lane_data;
  end

  assign trace_checksum = cks_q;
`else
  assign trace_checksum = '0;
`endif

endmodule

// File: tb/tb_nios_base_cpu_oci_trace_drain.sv
// Self-checking bench for nios_base_cpu_oci_trace_drain (default parameters).
// A queue of expected lanes plus a word count models the FIFO; outputs are
// compared every cycle, and directed scenarios add explicit value checks.
module tb_nios_base_cpu_oci_trace_drain;

  localparam int unsigned LANE_W = 10;
  localparam int unsigned LANES  = 3;
  localparam int unsigned DEPTH  = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid, test_ending, test_has_ended, lane_ready;
  logic [9:0]  lane_data, trace_checksum;
  logic        lane_valid, lane_last, overflow, drained;
  logic [15:0] dropped_count;

  always #5 clk = ~clk;

  nios_base_cpu_oci_trace_drain dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .lane_data      (lane_data),
    .lane_valid     (lane_valid),
    .lane_ready     (lane_ready),
    .lane_last      (lane_last),
    .overflow       (overflow),
    .dropped_count  (dropped_count),
    .drained        (drained),
    .trace_checksum (trace_checksum)
  );

  typedef struct {
    logic [9:0] d;
    bit         last;
  } lane_t;

  // Reference model: flattened lanes still to emit, words held, phase
  lane_t      mq[$];
  int         m_words;
  int         m_phase;   // 0 running, 1 draining, 2 finished
  bit         m_ovf;
  int         m_drops;
  logic [9:0] m_cks;

  int n_pass  = 0;
  int n_total = 0;
  int obs_lanes = 0;
  int obs_words = 0;
  int base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_words = 0;
    m_phase = 0;
    m_ovf   = 0;
    m_drops = 0;
    m_cks   = '0;
  endtask

  // Apply one clock edge of the specified behaviour to the model
  task automatic model_step();
    int  pre, eff;
    bit  hv;
    if (!reset_n) begin
      model_reset();
      return;
    end
    pre = m_words;
    hv  = (pre > 0) && (m_phase != 2);
    eff = (dct_count > 4'd3) ? 3 : int'(dct_count);
    if (hv && lane_ready) begin
      m_cks ^= mq[0].d;
      if (mq[0].last) m_words--;
      void'(mq.pop_front());
    end
    if (m_phase == 0 && dct_valid && eff != 0) begin
      if (pre < int'(DEPTH)) begin
        for (int l = 0; l < eff; l++) begin
          lane_t e;
          e.d    = dct_buffer[l*LANE_W +: LANE_W];
          e.last = (l == eff - 1);
          mq.push_back(e);
        end
        m_words++;
      end else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (test_has_ended) begin
      m_phase = 2;
      mq.delete();
      m_words = 0;
    end else if (m_phase == 0 && test_ending) begin
      m_phase = 1;
    end else if (m_phase == 1 && pre == 0) begin
      m_phase = 2;
    end
  endtask

  // One cycle: compare outputs mid-cycle, then clock and update the model
  task automatic cyc();
    bit         ev;
    logic [9:0] ed, ec;
    bit         el;
    #3;
    ev = (m_words > 0) && (m_phase != 2);
    ed = ev ? mq[0].d : 10'h000;
    el = ev ? mq[0].last : 1'b0;
`ifdef NIOS_OCI_TRACE_CHECKSUM_EN
    ec = m_cks;
`else
    ec = 10'h000;
`endif
    check("lane_valid", 32'(lane_valid), 32'(ev));
    check("lane_data", 32'(lane_data), 32'(ed));
    check("lane_last", 32'(lane_last), 32'(el));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("dropped_count", 32'(dropped_count), 32'(m_drops));
    check("drained", 32'(drained), 32'(m_phase == 2));
    check("trace_checksum", 32'(trace_checksum), 32'(ec));
    if (lane_valid && lane_ready) begin
      obs_lanes++;
      if (lane_last) obs_words++;
    end
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle_inputs();
    dct_valid      = 1'b0;
    dct_count      = 4'd0;
    dct_buffer     = '0;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    lane_ready     = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset with active capture inputs: nothing may be captured
    idle_inputs();
    reset_n    = 1'b0;
    dct_valid  = 1'b1;
    dct_count  = 4'd3;
    dct_buffer = 30'h2AAA_5555;
    model_reset();
    @(posedge clk);
    #1;
    cyc();
    cyc();
    check("rst_lane_valid", 32'(lane_valid), 32'd0);
    check("rst_drained", 32'(drained), 32'd0);
    reset_n   = 1'b1;
    dct_valid = 1'b0;
    cyc();
    check("post_rst_valid", 32'(lane_valid), 32'd0);
    cyc();

    // Basic serialise: two lanes of {155, 0AA, 001}
    dct_buffer = {10'h155, 10'h0AA, 10'h001};
    dct_count  = 4'd2;
    dct_valid  = 1'b1;
    cyc();
    dct_valid = 1'b0;
    #3;
    check("basic_l0_data", 32'(lane_data), 32'h001);
    check("basic_l0_last", 32'(lane_last), 32'd0);
    cyc();
    #3;
    check("basic_l1_data", 32'(lane_data), 32'h0AA);
    check("basic_l1_last", 32'(lane_last), 32'd1);
    cyc();
    #3;
    check("basic_empty", 32'(lane_valid), 32'd0);
`ifdef NIOS_OCI_TRACE_CHECKSUM_EN
    check("basic_checksum", 32'(trace_checksum), 32'h0AB);
`endif
    cyc();

    // Count boundaries: zero is ignored, five is clamped to three
    dct_count  = 4'd0;
    dct_valid  = 1'b1;
    cyc();
    dct_valid = 1'b0;
    cyc();
    check("cnt0_no_push", 32'(lane_valid), 32'd0);
    check("cnt0_no_drop", 32'(dropped_count), 32'd0);
    base       = obs_lanes;
    dct_buffer = 30'($urandom);
    dct_count  = 4'd5;
    dct_valid  = 1'b1;
    cyc();
    dct_valid = 1'b0;
    cyc();
    cyc();
    #3;
    check("cnt5_third_last", 32'(lane_last), 32'd1);
    cyc();
    cyc();
    check("cnt5_lanes", 32'(obs_lanes - base), 32'd3);

    // Overflow: ten pushes into a stalled FIFO
    lane_ready = 1'b0;
    dct_count  = 4'd3;
    dct_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dct_buffer = 30'($urandom);
      cyc();
    end
    dct_valid = 1'b0;
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drops", 32'(dropped_count), 32'd2);
    base       = obs_words;
    lane_ready = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    check("ovf_words_out", 32'(obs_words - base), 32'd8);
    check("ovf_hold_drops", 32'(dropped_count), 32'd2);

    // Drain: 3 words queued, test_ending pulse, capture must stop
    do_reset();
    lane_ready = 1'b0;
    dct_count  = 4'd2;
    dct_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dct_buffer = 30'($urandom);
      cyc();
    end
    dct_valid   = 1'b0;
    test_ending = 1'b1;
    cyc();
    test_ending = 1'b0;
    dct_valid   = 1'b1;
    dct_buffer  = 30'($urandom);
    base        = obs_words;
    lane_ready  = 1'b1;
    for (int i = 0; i < 12; i++) cyc();
    check("drain_words", 32'(obs_words - base), 32'd3);
    check("drain_done", 32'(drained), 32'd1);

    // Abort mid-drain with 2 words queued
    do_reset();
    lane_ready = 1'b0;
    dct_count  = 4'd3;
    dct_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dct_buffer = 30'($urandom);
      cyc();
    end
    dct_valid   = 1'b0;
    test_ending = 1'b1;
    cyc();
    test_ending    = 1'b0;
    test_has_ended = 1'b1;
    cyc();
    test_has_ended = 1'b0;
    dct_valid      = 1'b1;
    lane_ready     = 1'b1;
    #3;
    check("abort_valid", 32'(lane_valid), 32'd0);
    check("abort_drained", 32'(drained), 32'd1);
    cyc();
    cyc();
    check("abort_ignores_valid", 32'(lane_valid), 32'd0);

    // Randomised rounds against the model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        dct_valid      = ($urandom_range(0, 3) != 0);
        dct_count      = 4'($urandom_range(0, 15));
        dct_buffer     = 30'($urandom);
        lane_ready     = ($urandom_range(0, 2) != 0);
        test_ending    = ($urandom_range(0, 149) == 0);
        test_has_ended = ($urandom_range(0, 599) == 0);
        cyc();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
